apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master.sv | 111 +++++++++++
 tb/tb_apb_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared defaults and FSM state type for the APB master slice.
package apb_pkg;

  localparam int DEFAULT_AWIDTH = 8;
  localparam int DEFAULT_DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for p_ready and flags when the limit is hit.
// A TIMEOUT of 0 disables the limit: the counter never moves and expired stays low.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Saturating wait counter: cleared on entry to ACCESS, bumped on each stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT > 0) && (count == LIMIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: takes a command, runs SETUP/ACCESS,
// returns a one-cycle response pulse, and aborts stalled transfers.
module apb_master
  import apb_pkg::*;
#(
  parameter int AWIDTH  = DEFAULT_AWIDTH,
  parameter int DWIDTH  = DEFAULT_DWIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              p_sel,
  output logic              p_en,
  output logic              p_write,
  output logic [AWIDTH-1:0] addr,
  output logic [DWIDTH-1:0] wdata,
  input  logic [DWIDTH-1:0] rdata,
  input  logic              p_ready
);

  apb_state_e state, state_next;
  logic timer_clear, timer_inc, timer_expired;
  logic access_done, access_abort;

  // Success beats timeout when p_ready shows up on the expiring cycle.
  assign access_done  = (state == ACCESS) && p_ready;
  assign access_abort = (state == ACCESS) && !p_ready && timer_expired;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: SETUP always lasts one cycle, ACCESS waits for ready or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (access_done || access_abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and wait-timer controls.
  always_comb begin
    cmd_ready   = (state == IDLE) && !rst;
    busy        = (state != IDLE);
    p_sel       = (state == SETUP) || (state == ACCESS);
    p_en        = (state == ACCESS);
    timer_clear = (state == SETUP);
    timer_inc   = (state == ACCESS) && !p_ready;
  end

  // Capture the command on acceptance; the APB fields then hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_write <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
    end else if ((state == IDLE) && cmd_valid) begin
      p_write <= cmd_write;
      addr    <= cmd_addr;
      wdata   <= cmd_wdata;
    end
  end

  // Response pulse; data and error flag persist until the next response.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (access_done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= p_write ? '0 : rdata;
      end else if (access_abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .inc     (timer_inc),
    .expired (timer_expired)
  );

endmodule

// File: tb/tb_apb_master.sv
// Randomised scoreboard bench for apb_master with a memory-backed APB slave.
module tb_apb_master;

  localparam int AW     = 8;
  localparam int DW     = 32;
  localparam int TO     = 16;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic          p_sel, p_en, p_write, p_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  typedef struct {
    bit          err;
    logic [DW-1:0] rdata;
    int          access_cycles;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem   [0:255];
  logic [DW-1:0] slave_mem [0:255];

  int  checks = 0;
  int  passes = 0;
  int  proto_viol = 0;
  int  stab_viol = 0;
  int  hold_viol = 0;
  int  cur_waits = 0;
  int  slave_waited = 0;
  bit  in_reset = 1'b1;
  bit  spacing_on = 1'b0;
  bit  have_accept = 1'b0;
  time last_accept = 0;

  apb_master #(
    .AWIDTH  (AW),
    .DWIDTH  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .p_sel     (p_sel),
    .p_en      (p_en),
    .p_write   (p_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .p_ready   (p_ready)
  );

  // Free-running clock.
  initial forever #(PERIOD / 2) clk = ~clk;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #(PERIOD * 50000);
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void checkOutput(string name, logic [DW-1:0] actual, logic [DW-1:0] required);
    checks++;
    if (actual === required) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
  endfunction

  // Reference model: what the response should be, given how long the slave stalls.
  function automatic exp_t model(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int waits);
    exp_t e;
    bit abort;
    abort = (TO > 0) && (waits > TO);
    e.err = abort;
    e.access_cycles = abort ? TO + 1 : waits + 1;
    e.rdata = (abort || wr) ? '0 : ref_mem[a];
    if (wr && !abort) ref_mem[a] = d;
    return e;
  endfunction

  // APB slave: stalls for cur_waits ACCESS cycles, then completes from its memory.
  initial begin
    p_ready = 1'b0;
    rdata   = '0;
    forever begin
      @(negedge clk);
      if (p_sel && p_en) begin
        if (slave_waited < cur_waits) begin
          p_ready = 1'b0;
          rdata   = $urandom;
          slave_waited++;
        end else begin
          p_ready = 1'b1;
          rdata   = slave_mem[addr];
          if (p_write) slave_mem[addr] = wdata;
        end
      end else begin
        p_ready      = 1'b0;
        slave_waited = 0;
        rdata        = $urandom;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pop on each response pulse.
  initial begin : monitor
    int            sel_cnt, en_cnt;
    bit            have_last;
    logic [DW-1:0] last_rdata;
    logic          last_err;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_write;
    exp_t          e;
    sel_cnt = 0; en_cnt = 0; have_last = 1'b0;
    last_rdata = '0; last_err = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_write = 1'b0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        sel_cnt   = 0;
        en_cnt    = 0;
        have_last = 1'b0;
      end else begin
        if (p_en && !p_sel) proto_viol++;
        if (busy !== p_sel) proto_viol++;
        if (cmd_ready !== !busy) proto_viol++;
        if (p_sel && !p_en) begin
          cap_addr = addr; cap_wdata = wdata; cap_write = p_write;
        end else if (p_en) begin
          if (addr !== cap_addr || wdata !== cap_wdata || p_write !== cap_write) stab_viol++;
        end
        if (p_sel) sel_cnt++;
        if (p_en) en_cnt++;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_rsp_valid", DW'(rsp_valid), '0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_err", DW'(rsp_err), DW'(e.err));
            checkOutput("rsp_rdata", rsp_rdata, e.rdata);
            checkOutput("access_cycles", DW'(en_cnt), DW'(e.access_cycles));
            checkOutput("select_cycles", DW'(sel_cnt), DW'(e.access_cycles + 1));
          end
          sel_cnt    = 0;
          en_cnt     = 0;
          have_last  = 1'b1;
          last_rdata = rsp_rdata;
          last_err   = rsp_err;
        end else if (have_last) begin
          if (rsp_rdata !== last_rdata || rsp_err !== last_err) hold_viol++;
        end
      end
    end
  end

  // Issue one command, push its expected response, return in the SETUP cycle.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input int waits);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("cmd_ready_wait", DW'(cmd_ready), DW'(1));
      cmd_valid = 1'b0;
      return;
    end
    if (spacing_on && have_accept)
      checkOutput("cmd_spacing", DW'(($time - last_accept) / PERIOD), DW'(3));
    last_accept = $time;
    have_accept = 1'b1;
    cur_waits   = waits;
    e = model(wr, a, d, waits);
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    checkOutput("setup_addr", DW'(addr), DW'(a));
    checkOutput("setup_wdata", wdata, d);
    checkOutput("setup_write", DW'(p_write), DW'(wr));
  endtask

  // Hold reset for some cycles, checking every output is cleared.
  task automatic applyReset(input int cycles);
    in_reset = 1'b1;
    rst      = 1'b1;
    exp_q.delete();
    repeat (cycles) begin
      @(negedge clk);
      checkOutput("reset_ctrl", DW'({p_sel, p_en, p_write, rsp_valid, rsp_err, busy, cmd_ready}), '0);
      checkOutput("reset_addr", DW'(addr), '0);
      checkOutput("reset_wdata", wdata, '0);
      checkOutput("reset_rsp_rdata", rsp_rdata, '0);
    end
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;
    checkOutput("ready_after_reset", DW'(cmd_ready), DW'(1));
  endtask

  // Directed scenarios, streaming, then a randomised mix.
  initial begin
    int n;
    int r;
    int w;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    @(negedge clk);
    applyReset(3);

    applyStimulus(1'b1, 8'd23, 32'd55, 0);
    applyStimulus(1'b0, 8'd23, 32'd0, 0);
    applyStimulus(1'b1, 8'd40, 32'hA5A5_0001, 3);
    applyStimulus(1'b0, 8'd40, 32'd0, 3);
    applyStimulus(1'b1, 8'd41, 32'hDEAD_BEEF, 1000);
    applyStimulus(1'b0, 8'd41, 32'd0, 0);
    applyStimulus(1'b0, 8'd23, 32'd0, TO);
    applyStimulus(1'b0, 8'd40, 32'd0, TO + 1);
    applyStimulus(1'b0, 8'd40, 32'd0, TO - 1);

    applyStimulus(1'b0, 8'd23, 32'd0, 6);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_access_p_en", DW'(p_en), DW'(1));
    applyReset(1);
    applyStimulus(1'b0, 8'd23, 32'd0, 0);

    spacing_on  = 1'b1;
    have_accept = 1'b0;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, AW'(i), DW'(2 * i), 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, AW'(i), '0, 0);
    spacing_on = 1'b0;

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      w = $urandom_range(0, 2);
      else if (r < 8) w = $urandom_range(3, 6);
      else            w = $urandom_range(TO - 1, TO + 2);
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, w);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("pending_responses", DW'(exp_q.size()), '0);
    checkOutput("protocol_violations", DW'(proto_viol), '0);
    checkOutput("stability_violations", DW'(stab_viol), '0);
    checkOutput("hold_violations", DW'(hold_viol), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
